pong_game_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 14 +
 rtl/pong_game_ctrl_bcd2_counter.sv | 14 +
 rtl/pong_game_ctrl.sv | 94 +++++++++
 tb/tb_pong_game_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared types, constants and BCD helpers for the pong game-flow controller.
package pong_pkg;
    typedef enum logic [1:0] {NEWGAME = 2'd0, PLAY = 2'd1, NEWBALL = 2'd2, OVER = 2'd3} state_t;
    typedef logic [7:0] bcd2_t;
    localparam int REFRESH_HZ = 60;
    localparam bcd2_t BCD_MAX = 8'h99;
    function automatic bcd2_t to_bcd2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction
    // Two-digit BCD increment that holds at 99.
    function automatic bcd2_t bcd_inc(input bcd2_t q);
        return (q == BCD_MAX) ? q : (q[3:0] == 4'd9) ? {q[7:4] + 4'd1, 4'd0} : {q[7:4], q[3:0] + 4'd1};
    endfunction
endpackage

// File: rtl/pong_game_ctrl_bcd2_counter.sv
// bcd2_counter: two-digit BCD score counter, saturating at 99.
module bcd2_counter
    import pong_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clr,
    input  logic  inc,
    output bcd2_t q
);
    always_ff @(posedge clk)
        if (reset || clr) q <= '0;
        else if (inc) q <= bcd_inc(q);
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match FSM, BCD scores and serve/game-over timers for pong.
// Optional rally counter output enabled by RALLY_CNT_EN.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE     = 11,
    parameter int NEWBALL_TICKS = 120,
    parameter int OVER_TICKS    = 180,
    parameter int TMR_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic [3:0] btn,
    input  logic [1:0] hit,
    input  logic       miss,
    input  logic       ball_right,
    output logic       gra_still,
    output logic [7:0] score_l,
    output logic [7:0] score_r,
    output logic [1:0] state,
    output logic       game_over,
    output logic       winner
`ifdef RALLY_CNT_EN
    ,
    output logic [7:0] rally
`endif
);
    localparam bcd2_t WIN_BCD = to_bcd2(WIN_SCORE);
    state_t           r_state, w_next;
    logic [TMR_W-1:0] r_tmr, w_tmr;
    logic             r_arm, w_arm, r_winner, w_winner;
    logic             w_start, w_pt, w_won;
    assign w_start = (r_state == NEWGAME) && r_arm && |btn;
    assign w_pt    = (r_state == PLAY) && miss;
    assign w_won   = (ball_right ? bcd_inc(score_l) : bcd_inc(score_r)) == WIN_BCD;
    assign state   = r_state;
    assign winner  = r_winner;
    always_comb begin
        w_next   = r_state;
        w_tmr    = r_tmr;
        w_arm    = 1'b0;
        w_winner = r_winner;
        case (r_state)
            NEWGAME: begin
                w_arm  = r_arm | ~|btn;
                w_next = w_start ? PLAY : NEWGAME;
            end
            PLAY: if (miss) begin
                w_next   = w_won ? OVER : NEWBALL;
                w_tmr    = w_won ? TMR_W'(OVER_TICKS - 1) : TMR_W'(NEWBALL_TICKS - 1);
                w_winner = w_won ? ~ball_right : r_winner;
            end
            default: if (refresh_tick) begin
                w_next = (r_tmr != '0) ? r_state : (r_state == OVER) ? NEWGAME : PLAY;
                w_tmr  = (r_tmr != '0) ? r_tmr - 1'b1 : r_tmr;
            end
        endcase
    end
    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk)
        if (reset) begin
            r_state   <= NEWGAME;
            r_tmr     <= '0;
            r_arm     <= 1'b0;
            r_winner  <= 1'b0;
            gra_still <= 1'b1;
            game_over <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_tmr     <= w_tmr;
            r_arm     <= w_arm;
            r_winner  <= w_winner;
            gra_still <= (w_next != PLAY);
            game_over <= (w_next == OVER);
        end
    bcd2_counter u_left  (.clk(clk), .reset(reset), .clr(w_start), .inc(w_pt && ball_right),  .q(score_l));
    bcd2_counter u_right (.clk(clk), .reset(reset), .clr(w_start), .inc(w_pt && !ball_right), .q(score_r));
`ifdef RALLY_CNT_EN
    logic r_hit_d;
    always_ff @(posedge clk)
        if (reset) begin
            r_hit_d <= 1'b0;
            rally   <= '0;
        end else begin
            r_hit_d <= |hit;
            if (r_state != PLAY && w_next == PLAY) rally <= '0;
            else if (r_state == PLAY && |hit && !r_hit_d && rally != 8'hFF) rally <= rally + 8'd1;
        end
`else
    logic w_unused_hit;
    assign w_unused_hit = ^hit;
`endif
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed plus random checks of two controller builds against an integer game model.
module tb_pong_game_ctrl;
    logic       clk = 1'b0, reset = 1'b1, refresh_tick = 1'b0, miss = 1'b0, ball_right = 1'b0;
    logic [3:0] btn = '0;
    logic [1:0] hit = '0;
    logic       g0, go0, w0, g1, go1, w1;
    logic [7:0] sl0, sr0, sl1, sr1, ra0, ra1;
    logic [1:0] st0, st1;
    int         n_cmp = 0, n_bad = 0;
    typedef struct {
        int st; int sl; int sr; int tmr; int arm; int win; int rally; int hd;
    } mdl_t;
    mdl_t m0, m1;
    always #5 clk = ~clk;
    pong_game_ctrl u0 (
        .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .btn(btn), .hit(hit), .miss(miss),
        .ball_right(ball_right), .gra_still(g0), .score_l(sl0), .score_r(sr0), .state(st0),
        .game_over(go0), .winner(w0)
`ifdef RALLY_CNT_EN
        , .rally(ra0)
`endif
    );
    pong_game_ctrl #(.WIN_SCORE(1), .NEWBALL_TICKS(2), .OVER_TICKS(3), .TMR_W(8)) u1 (
        .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .btn(btn), .hit(hit), .miss(miss),
        .ball_right(ball_right), .gra_still(g1), .score_l(sl1), .score_r(sr1), .state(st1),
        .game_over(go1), .winner(w1)
`ifdef RALLY_CNT_EN
        , .rally(ra1)
`endif
    );
    function automatic int bcd(int n);
        return (n / 10) * 16 + n % 10;
    endfunction
    // Game rules in integer terms: 0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER.
    function automatic mdl_t nxt(mdl_t m, int win, int nb, int ov);
        mdl_t n = m;
        int   sc;
        if (reset) return '{default: 0};
        n.arm = 0;
        if (m.st == 0) begin
            n.arm = (m.arm != 0 || btn == 0) ? 1 : 0;
            if (m.arm != 0 && btn != 0) begin n.st = 1; n.sl = 0; n.sr = 0; end
        end else if (m.st == 1) begin
            if (miss) begin
                if (ball_right) n.sl = (m.sl < 99) ? m.sl + 1 : 99;
                else n.sr = (m.sr < 99) ? m.sr + 1 : 99;
                sc = ball_right ? n.sl : n.sr;
                if (sc == win) begin n.st = 3; n.win = ball_right ? 0 : 1; n.tmr = ov - 1; end
                else begin n.st = 2; n.tmr = nb - 1; end
            end
        end else if (refresh_tick) begin
            if (m.tmr == 0) n.st = (m.st == 3) ? 0 : 1;
            else n.tmr = m.tmr - 1;
        end
        if (m.st != 1 && n.st == 1) n.rally = 0;
        else if (m.st == 1 && hit != 0 && m.hd == 0) n.rally = (m.rally < 255) ? m.rally + 1 : 255;
        n.hd = (hit != 0) ? 1 : 0;
        return n;
    endfunction
    function automatic logic [20:0] exp_of(mdl_t m);
        return {2'(m.st), 1'(m.st != 1), 1'(m.st == 3), 1'(m.win), 8'(bcd(m.sl)), 8'(bcd(m.sr))};
    endfunction
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step(logic r, logic [3:0] b, logic [1:0] h, logic mi, logic br, logic rt);
        reset = r; btn = b; hit = h; miss = mi; ball_right = br; refresh_tick = rt;
        @(posedge clk);
        #1;
        m0 = nxt(m0, 11, 120, 180);
        m1 = nxt(m1, 1, 2, 3);
        chk("dut_w11", {11'd0, st0, g0, go0, w0, sl0, sr0}, {11'd0, exp_of(m0)});
        chk("dut_w1", {11'd0, st1, g1, go1, w1, sl1, sr1}, {11'd0, exp_of(m1)});
`ifdef RALLY_CNT_EN
        chk("rally_w11", {24'd0, ra0}, 32'(m0.rally));
        chk("rally_w1", {24'd0, ra1}, 32'(m1.rally));
`endif
    endtask
    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            step(0, 4'd0, 2'd0, 0, 0, 1);
            step(0, 4'd0, 2'd0, 0, 0, 0);
        end
    endtask
    initial begin
        m0 = '{default: 0};
        m1 = '{default: 0};
        step(1, 4'b0001, 2'd0, 0, 0, 0);
        step(1, 4'b0001, 2'd0, 0, 0, 0);
        chk("reset_still", {31'd0, g0}, 32'd1);
        for (int i = 0; i < 3; i++) step(0, 4'b0001, 2'd0, 0, 0, 0);
        chk("held_btn_newgame", {30'd0, st0}, 32'd0);
        step(0, 4'b0000, 2'd0, 0, 0, 0);
        step(0, 4'b0100, 2'd0, 0, 0, 0);
        chk("start_play", {30'd0, st0}, 32'd1);
        chk("start_still", {31'd0, g0}, 32'd0);
        for (int i = 0; i < 5; i++) step(0, 4'd0, 2'd0, 1, 1, 0);
        chk("one_point", {24'd0, sl0}, 32'h01);
        chk("newball", {30'd0, st0}, 32'd2);
        chk("w1_direct_over", {30'd0, st1}, 32'd3);
        chk("w1_game_over", {31'd0, go1}, 32'd1);
        ticks(119);
        chk("newball_119", {30'd0, st0}, 32'd2);
        ticks(1);
        chk("newball_120", {30'd0, st0}, 32'd1);
        step(0, 4'd0, 2'b01, 1, 1, 0);
        chk("hit_miss_state", {30'd0, st0}, 32'd2);
        chk("hit_miss_score", {24'd0, sl0}, 32'h02);
        ticks(120);
        for (int i = 0; i < 7; i++) begin
            step(0, 4'd0, 2'd0, 1, 1, 0);
            ticks(120);
        end
        chk("score_09", {24'd0, sl0}, 32'h09);
        step(0, 4'd0, 2'd0, 1, 1, 0);
        chk("score_10", {24'd0, sl0}, 32'h10);
        ticks(120);
        step(0, 4'd0, 2'd0, 1, 1, 0);
        chk("win_state", {30'd0, st0}, 32'd3);
        chk("win_left", {30'd0, go0, w0}, 32'b10);
        ticks(179);
        chk("over_179", {30'd0, st0}, 32'd3);
        ticks(1);
        chk("over_done", {30'd0, st0}, 32'd0);
        chk("scores_held", {16'd0, sl0, sr0}, 32'h1100);
        step(0, 4'b0000, 2'd0, 0, 0, 0);
        step(0, 4'b1000, 2'd0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 4'd0, 2'b01, 0, 0, 0);
`ifdef RALLY_CNT_EN
        chk("rally_held_hit", {24'd0, ra0}, 32'd1);
`endif
        step(0, 4'd0, 2'd0, 1, 0, 0);
        chk("right_point", {24'd0, sr0}, 32'h01);
        ticks(69);
        step(1, 4'd0, 2'd0, 0, 0, 0);
        chk("mid_reset", {16'd0, st0, g0, go0, w0, sl0, 3'd0}, {16'd0, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0});
        for (int i = 0; i < 4000; i++)
            step(($urandom % 600) == 0, (($urandom % 6) == 0) ? 4'($urandom) : 4'd0, 2'($urandom),
                 ($urandom % 8) == 0, 1'($urandom), 1'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
